// File: rtl/seq_mult_param_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier.
package seq_mult_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Constant-evaluable ceil(log2(v)); used to size the skip-count bus.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Start/done handshake bundle between the controller and the multiplier.
interface seq_mult_param_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 mode_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, mode_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, mode_signed, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_mult_tzc.sv
// Trailing-zero count of the low multiplier bits, saturating at MAX_SKIP.
module seq_mult_tzc
  import seq_mult_param_pkg::*;
#(
  parameter int MAX_SKIP = 16,
  parameter int CW       = clog2(MAX_SKIP + 1)
) (
  input  logic [MAX_SKIP-1:0] mb_i,
  output logic [CW-1:0]       cnt_o
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    cnt_o = CW'(MAX_SKIP);
    for (int i = MAX_SKIP - 1; i >= 0; i--) begin
      if (mb_i[i]) cnt_o = CW'(i);
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with signed/unsigned mode, zero-run
// skipping and early termination once the remaining multiplier is zero.
module seq_mult_param
  import seq_mult_param_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_SKIP = 16
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_param_if.slave   bus
);

  localparam int CW = clog2(MAX_SKIP + 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        skip_cnt;
  logic [WIDTH-1:0]     a_mag, b_mag;

  seq_mult_tzc #(
    .MAX_SKIP (MAX_SKIP),
    .CW       (CW)
  ) u_tzc (
    .mb_i  (mb_q[MAX_SKIP-1:0]),
    .cnt_o (skip_cnt)
  );

  // The most negative operand negates to itself, which read unsigned is its magnitude.
  assign a_mag = (bus.mode_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.mode_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      product_q <= product_d;
      neg_q     <= neg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    product_d = product_q;
    neg_d     = neg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          neg_d   = bus.mode_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          ma_d    = {{WIDTH{1'b0}}, a_mag};
          mb_d    = b_mag;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mb_q == '0) begin
          product_d = neg_q ? -acc_q : acc_q;
          state_d   = ST_DONE;
        end else if (mb_q[0]) begin
          acc_d = acc_q + ma_q;
          ma_d  = ma_q << 1;
          mb_d  = mb_q >> 1;
        end else begin
          ma_d = ma_q << skip_cnt;
          mb_d = mb_q >> skip_cnt;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;

endmodule
